// File: rtl/decoder_stage_controller.sv
// Global stage sequencer for the processing_unit array.
// Broadcasts the current decode stage to every PE and watches the OR-reduced
// busy/odd flags to decide when each stage has settled. A round runs
// LOAD -> (GROW -> MERGE)* -> PEEL -> DONE and ends with a one-cycle result_valid.
module decoder_stage_controller #(
    parameter int PU_COUNT      = 64,
    parameter int ITER_WIDTH    = 8,
    parameter int MAX_GROW_ITER = 31,
    parameter int LOAD_CYCLES   = 3,
    parameter int MIN_DWELL     = 3,
    parameter int SETTLE        = 2,
    parameter int CYCLE_WIDTH   = 16,
    parameter int STAGE_WIDTH   = 3,
    // Stage codes shared with the PEs; must match the PE-side encoding.
    parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE                = STAGE_WIDTH'(0),
    parameter logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = STAGE_WIDTH'(1),
    parameter logic [STAGE_WIDTH-1:0] STAGE_GROW                = STAGE_WIDTH'(2),
    parameter logic [STAGE_WIDTH-1:0] STAGE_MERGE               = STAGE_WIDTH'(3),
    parameter logic [STAGE_WIDTH-1:0] STAGE_PEELING             = STAGE_WIDTH'(4)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [PU_COUNT-1:0]    busy,
    input  logic [PU_COUNT-1:0]    odd,
    output logic [STAGE_WIDTH-1:0] global_stage,
    output logic                   result_valid,
    output logic [ITER_WIDTH-1:0]  iteration,
    output logic [CYCLE_WIDTH-1:0] cycle_count,
    output logic                   overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GROW,
        S_MERGE,
        S_PEEL,
        S_DONE
    } state_t;

    localparam int CNT_WIDTH = 8;
    // The first two any_busy_q samples after a stage change still describe the
    // previous stage (PE busy register + OR register), so they are not counted
    // as quiet evidence for the new stage.
    localparam int QUIET_START = 2;

    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_WIDTH-1:0]  LOAD_LAST  = CNT_WIDTH'(LOAD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  DWELL_MIN  = CNT_WIDTH'(MIN_DWELL);
    localparam logic [CNT_WIDTH-1:0]  QUIET_FROM = CNT_WIDTH'(QUIET_START);
    localparam logic [CNT_WIDTH-1:0]  QUIET_SAT  = CNT_WIDTH'(SETTLE);
    localparam logic [ITER_WIDTH-1:0] ITER_LIMIT = ITER_WIDTH'(MAX_GROW_ITER);

    state_t                 state_reg;
    logic                   any_busy_q;
    logic                   any_odd_q;
    logic [CNT_WIDTH-1:0]   stage_cnt_reg;
    logic [CNT_WIDTH-1:0]   quiet_cnt_reg;
    logic [CNT_WIDTH-1:0]   stage_cnt_next;
    logic [CNT_WIDTH-1:0]   quiet_cnt_next;
    logic [CYCLE_WIDTH-1:0] cycle_count_next;
    logic                   settled;
    logic                   leaving;

    // A MERGE/PEEL stage is settled once the minimum dwell has elapsed and the
    // flags have been quiet for SETTLE consecutive counted samples.
    assign settled = (stage_cnt_reg >= DWELL_MIN) && (quiet_cnt_reg == QUIET_SAT);

    // Saturating counter increments for stage age, quiet run and round length.
    always_comb begin
        stage_cnt_next   = (stage_cnt_reg == CNT_MAX) ? stage_cnt_reg
                                                      : stage_cnt_reg + CNT_WIDTH'(1);
        cycle_count_next = (cycle_count == '1) ? cycle_count
                                               : cycle_count + CYCLE_WIDTH'(1);
        quiet_cnt_next   = quiet_cnt_reg;
        if (stage_cnt_reg >= QUIET_FROM) begin
            if (any_busy_q) begin
                quiet_cnt_next = '0;
            end else if (quiet_cnt_reg < QUIET_SAT) begin
                quiet_cnt_next = quiet_cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

    // Flags the last cycle of the current state so per-state counters restart.
    always_comb begin
        leaving = 1'b0;
        case (state_reg)
            S_IDLE:          leaving = start;
            S_LOAD:          leaving = (stage_cnt_reg == LOAD_LAST);
            S_GROW, S_DONE:  leaving = 1'b1;
            S_MERGE, S_PEEL: leaving = settled;
            default:         leaving = 1'b1;
        endcase
    end

    // Stage sequencer with registered stage broadcast, round statistics and flag pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            global_stage  <= STAGE_IDLE;
            result_valid  <= 1'b0;
            iteration     <= '0;
            cycle_count   <= '0;
            overflow      <= 1'b0;
            any_busy_q    <= 1'b0;
            any_odd_q     <= 1'b0;
            stage_cnt_reg <= '0;
            quiet_cnt_reg <= '0;
        end else begin
            any_busy_q    <= |busy;
            any_odd_q     <= |odd;
            result_valid  <= 1'b0;
            stage_cnt_reg <= leaving ? '0 : stage_cnt_next;
            quiet_cnt_reg <= leaving ? '0 : quiet_cnt_next;

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg    <= S_LOAD;
                        global_stage <= STAGE_MEASUREMENT_LOADING;
                        iteration    <= '0;
                        cycle_count  <= '0;
                        overflow     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    cycle_count <= cycle_count_next;
                    if (leaving) begin
                        if (any_odd_q) begin
                            state_reg    <= S_GROW;
                            global_stage <= STAGE_GROW;
                        end else begin
                            state_reg    <= S_PEEL;
                            global_stage <= STAGE_PEELING;
                        end
                    end
                end
                S_GROW: begin
                    cycle_count  <= cycle_count_next;
                    iteration    <= iteration + ITER_WIDTH'(1);
                    state_reg    <= S_MERGE;
                    global_stage <= STAGE_MERGE;
                end
                S_MERGE: begin
                    cycle_count <= cycle_count_next;
                    if (settled) begin
                        if (!any_odd_q) begin
                            state_reg    <= S_PEEL;
                            global_stage <= STAGE_PEELING;
                        end else if (iteration < ITER_LIMIT) begin
                            state_reg    <= S_GROW;
                            global_stage <= STAGE_GROW;
                        end else begin
                            state_reg    <= S_PEEL;
                            global_stage <= STAGE_PEELING;
                            overflow     <= 1'b1;
                        end
                    end
                end
                S_PEEL: begin
                    cycle_count <= cycle_count_next;
                    if (settled) begin
                        state_reg    <= S_DONE;
                        global_stage <= STAGE_PEELING;
                        result_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    cycle_count  <= cycle_count_next;
                    state_reg    <= S_IDLE;
                    global_stage <= STAGE_IDLE;
                end
                default: begin
                    state_reg    <= S_IDLE;
                    global_stage <= STAGE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Bench for decoder_stage_controller: directed round scenarios plus randomized
// rounds, checked every cycle against a history-based behavioural model.
module tb_decoder_stage_controller;

    localparam int PU   = 64;
    localparam int IW   = 8;
    localparam int MAXI = 4;
    localparam int LC   = 3;
    localparam int MD   = 3;
    localparam int ST   = 2;
    localparam int CW   = 16;
    localparam int SW   = 3;
    localparam int HIST = 32768;

    localparam logic [SW-1:0] G_IDLE  = 3'd0;
    localparam logic [SW-1:0] G_LOAD  = 3'd1;
    localparam logic [SW-1:0] G_GROW  = 3'd2;
    localparam logic [SW-1:0] G_MERGE = 3'd3;
    localparam logic [SW-1:0] G_PEEL  = 3'd4;

    // Model phases
    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_GROW  = 2;
    localparam int P_MERGE = 3;
    localparam int P_PEEL  = 4;
    localparam int P_DONE  = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [PU-1:0] busy = '0;
    logic [PU-1:0] odd = '0;
    logic [SW-1:0] global_stage;
    logic          result_valid;
    logic [IW-1:0] iteration;
    logic [CW-1:0] cycle_count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    decoder_stage_controller #(
        .PU_COUNT(PU), .ITER_WIDTH(IW), .MAX_GROW_ITER(MAXI), .LOAD_CYCLES(LC),
        .MIN_DWELL(MD), .SETTLE(ST), .CYCLE_WIDTH(CW), .STAGE_WIDTH(SW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .odd(odd),
        .global_stage(global_stage), .result_valid(result_valid),
        .iteration(iteration), .cycle_count(cycle_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Keeps a per-cycle history of the OR of busy/odd as driven, and decides each
    // stage exit by inspecting that history window directly.
    bit raw_b [HIST];
    bit raw_o [HIST];
    int m_t = 0;
    int m_phase = P_IDLE;
    int m_entry = 0;
    int m_iter = 0;
    int m_cc = 0;
    bit m_ovf = 1'b0;

    function automatic logic [SW-1:0] stage_of(input int p);
        case (p)
            P_LOAD:         return G_LOAD;
            P_GROW:         return G_GROW;
            P_MERGE:        return G_MERGE;
            P_PEEL, P_DONE: return G_PEEL;
            default:        return G_IDLE;
        endcase
    endfunction

    // Busy samples that reflect a stage appear from its third cycle onward; exit
    // needs the minimum dwell and SETTLE such samples in a row all idle.
    function automatic bit model_exit(input int t);
        int need;
        need = (MD > 2 + ST) ? MD : 2 + ST;
        if (t - m_entry < need) return 1'b0;
        for (int k = 1; k <= ST; k++)
            if (raw_b[t-1-k]) return 1'b0;
        return 1'b1;
    endfunction

    task model_step();
        int age;
        if (!reset_n) begin
            m_phase = P_IDLE; m_iter = 0; m_cc = 0; m_ovf = 1'b0;
            raw_b[m_t] = 1'b0; raw_o[m_t] = 1'b0;
            m_t++;
            return;
        end
        raw_b[m_t] = |busy;
        raw_o[m_t] = |odd;
        age = m_t - m_entry;
        if (m_phase != P_IDLE && m_cc < (1 << CW) - 1) m_cc++;
        case (m_phase)
            P_IDLE: if (start) begin
                m_phase = P_LOAD; m_entry = m_t + 1;
                m_iter = 0; m_ovf = 1'b0; m_cc = 0;
            end
            P_LOAD: if (age == LC - 1) begin
                m_phase = raw_o[m_t-1] ? P_GROW : P_PEEL; m_entry = m_t + 1;
            end
            P_GROW: begin
                m_iter++; m_phase = P_MERGE; m_entry = m_t + 1;
            end
            P_MERGE: if (model_exit(m_t)) begin
                if (!raw_o[m_t-1]) m_phase = P_PEEL;
                else if (m_iter < MAXI) m_phase = P_GROW;
                else begin m_phase = P_PEEL; m_ovf = 1'b1; end
                m_entry = m_t + 1;
            end
            P_PEEL: if (model_exit(m_t)) begin
                m_phase = P_DONE; m_entry = m_t + 1;
            end
            default: begin
                m_phase = P_IDLE; m_entry = m_t + 1;
            end
        endcase
        m_t++;
    endtask

    // Advance the model on each edge, then compare all outputs just after it.
    always @(posedge clk) begin
        model_step();
        #1;
        check("global_stage", global_stage, stage_of(m_phase));
        check("result_valid", result_valid, (m_phase == P_DONE));
        check("iteration", iteration, m_iter);
        check("cycle_count", cycle_count, m_cc);
        check("overflow", overflow, m_ovf);
    end

    // ---------------- stimulus ----------------
    task tick();
        @(negedge clk);
    endtask

    task automatic wait_stage(input logic [SW-1:0] s, input int budget, input string name);
        int n = 0;
        while (global_stage != s && n < budget) begin
            tick(); n++;
        end
        check(name, global_stage, s);
    endtask

    task automatic run_to_valid(input int budget, output int n);
        n = 1;
        while (!result_valid && n < budget) begin
            tick(); n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, len, grows, mode;
        bit aborted;
        logic [SW-1:0] prev;
        logic [SW-1:0] seq[$];
        logic [SW-1:0] exp_seq [6];

        // T1: reset with random inputs
        reset_n = 1'b0;
        repeat (4) begin
            busy = {$urandom, $urandom}; odd = {$urandom, $urandom};
            start = 1'($urandom_range(0, 1));
            tick();
        end
        check("t1_stage", global_stage, G_IDLE);
        check("t1_valid", result_valid, 0);
        check("t1_iteration", iteration, 0);
        check("t1_cycle_count", cycle_count, 0);
        check("t1_overflow", overflow, 0);
        start = 1'b0; busy = '0; odd = '0;
        tick();
        reset_n = 1'b1;
        tick();

        // T2: trivial round
        start = 1'b1; tick(); start = 1'b0;
        run_to_valid(100, n);
        check("t2_valid_cycle", n, 9);
        tick();
        check("t2_cycle_count", cycle_count, 9);
        check("t2_iteration", iteration, 0);
        check("t2_overflow", overflow, 0);
        check("t2_back_idle", global_stage, G_IDLE);
        $display("T2 trivial round: valid at cycle %0d, cycle_count=%0d", n, cycle_count);

        // T3: two growths
        odd[17] = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        prev = G_IDLE; grows = 0; n = 0;
        while (!result_valid && n < 400) begin
            if (global_stage != prev) begin
                seq.push_back(global_stage);
                prev = global_stage;
                if (global_stage == G_GROW) grows++;
            end
            if (grows == 2 && global_stage == G_MERGE) odd = '0;
            tick(); n++;
        end
        exp_seq = '{G_LOAD, G_GROW, G_MERGE, G_GROW, G_MERGE, G_PEEL};
        check("t3_seq_len", seq.size(), 6);
        for (int i = 0; i < 6 && i < seq.size(); i++)
            check("t3_seq_item", seq[i], exp_seq[i]);
        check("t3_valid", result_valid, 1);
        check("t3_iteration", iteration, 2);
        check("t3_overflow", overflow, 0);
        $display("T3 two growths: iteration=%0d stages=%0d", iteration, seq.size());
        tick();

        // T4: busy pulse in MERGE delays exit
        odd[40] = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        wait_stage(G_MERGE, 20, "t4_reach_merge");
        odd = '0;
        tick();
        busy[5] = 1'b1;
        repeat (3) tick();
        busy[5] = 1'b0;
        len = 4;
        while (global_stage == G_MERGE && len < 100) begin
            len++; tick();
        end
        check("t4_merge_len", len, 8);
        check("t4_next_peel", global_stage, G_PEEL);
        run_to_valid(100, n);
        check("t4_valid", result_valid, 1);
        check("t4_iteration", iteration, 1);
        $display("T4 busy re-arm: merge lasted %0d cycles", len);
        tick();

        // T5: overflow with odd stuck high
        odd = '1;
        start = 1'b1; tick(); start = 1'b0;
        prev = G_LOAD; grows = 0; n = 0;
        while (!result_valid && n < 1000) begin
            if (global_stage == G_GROW && prev != G_GROW) grows++;
            prev = global_stage;
            tick(); n++;
        end
        check("t5_valid", result_valid, 1);
        check("t5_grows", grows, 4);
        check("t5_iteration", iteration, 4);
        check("t5_overflow", overflow, 1);
        $display("T5 overflow: grows=%0d iteration=%0d overflow=%0d", grows, iteration, overflow);
        odd = '0;
        tick();

        // T6: start ignored in MERGE, reset aborts, fresh round completes
        odd[3] = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        wait_stage(G_MERGE, 20, "t6_reach_merge");
        tick();
        start = 1'b1; tick(); start = 1'b0;
        check("t6_start_ignored", global_stage, G_MERGE);
        reset_n = 1'b0;
        #1;
        check("t6_abort_stage", global_stage, G_IDLE);
        repeat (3) begin
            tick();
            check("t6_no_valid", result_valid, 0);
        end
        odd = '0;
        reset_n = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        run_to_valid(100, n);
        check("t6_fresh_round", n, 9);
        $display("T6 abort/restart: fresh round valid at cycle %0d", n);
        tick();

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            mode = $urandom_range(0, 2);
            busy = '0;
            odd = '0;
            repeat ($urandom_range(0, 3)) tick();
            if (mode == 1) odd = {$urandom, $urandom};
            if (mode == 2) odd = 64'd1 << $urandom_range(0, 63);
            start = 1'b1; tick(); start = 1'b0;
            aborted = 1'b0; n = 0;
            while (!result_valid && n < 800 && !aborted) begin
                busy = ($urandom_range(0, 3) == 0) ? (64'd1 << $urandom_range(0, 63)) : '0;
                if (mode == 1) odd = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : '0;
                start = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 299) == 0) begin
                    reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
                    aborted = 1'b1;
                end else begin
                    tick(); n++;
                end
            end
            start = 1'b0;
            busy = '0;
            if (!aborted) begin
                check("rand_round_done", result_valid, 1);
                $display("round %0d mode=%0d iteration=%0d overflow=%0d length=%0d",
                         r, mode, iteration, overflow, n);
            end else begin
                $display("round %0d mode=%0d aborted by reset", r, mode);
            end
            tick();
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
